// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: PC walker, single-outstanding imem requester and {pc, instr} FIFO.
// Define FETCH_STATS_EN to add the stat_fetched / stat_flushed counters.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed
`endif
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [31:0]   mem_addr_reg, mem_addr_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0] count_reg, count_next;
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic [31:0]   target_pc, seq_pc;
    logic          push, pop;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign seq_pc    = fetch_pc_reg + 32'd4;

    // A redirect kills both the returning word and any pop of now-stale entries.
    assign push = (state_reg == REQ) && mem_ack && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign count_next = redirect_valid ? '0 : (count_reg + CW'(push) - CW'(pop));

    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = target_pc;
            case (state_reg)
                IDLE: begin
                    state_next    = REQ;
                    mem_addr_next = target_pc;
                end
                REQ, DROP: begin
                    if (mem_ack) begin
                        state_next    = REQ;
                        mem_addr_next = target_pc;
                    end else begin
                        state_next = DROP;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else begin
            case (state_reg)
                IDLE: begin
                    if (count_reg < FULL) begin
                        state_next    = REQ;
                        mem_addr_next = fetch_pc_reg;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fetch_pc_next = seq_pc;
                        mem_addr_next = seq_pc;
                        state_next    = (count_next < FULL) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        state_next    = REQ;
                        mem_addr_next = fetch_pc_reg;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            mem_addr_reg <= RESET_PC & 32'hFFFF_FFFC;
            fetch_pc_reg <= RESET_PC & 32'hFFFF_FFFC;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            if (redirect_valid) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage is register based so the head is visible combinationally and clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    pc_mem[i]   <= mem_addr_reg;
                    data_mem[i] <= mem_rdata;
                end
            end
        end
    end

    assign mem_req    = (state_reg != IDLE);
    assign mem_addr   = mem_addr_reg;
    assign inst_valid = (count_reg != '0);
    assign inst_pc    = pc_mem[rd_ptr_reg];
    assign inst_data  = data_mem[rd_ptr_reg];

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_reg, stat_flushed_reg;
    logic        discard;

    // Only REQ holds a live request; in DROP it has already been written off.
    assign discard = redirect_valid && ((count_reg != '0) || (state_reg == REQ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched_reg <= '0;
            stat_flushed_reg <= '0;
        end else begin
            if (push)    stat_fetched_reg <= stat_fetched_reg + 32'd1;
            if (discard) stat_flushed_reg <= stat_flushed_reg + 32'd1;
        end
    end

    assign stat_fetched = stat_fetched_reg;
    assign stat_flushed = stat_flushed_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: queue-based fetch model checked every cycle,
// plus literal expectations for each scenario.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] PAT      = 32'h0000A5A5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: delivered-but-unconsumed entries, the one request in flight, next sequential PC.
    entry_t      m_q[$];
    logic        m_busy;
    logic        m_doomed;
    logic [31:0] m_addr;
    logic [31:0] m_next_pc;
`ifdef FETCH_STATS_EN
    int          m_pushes;
    int          m_flushes;
`endif

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_flushed   (stat_flushed)
`endif
    );

    assign mem_rdata = mem_addr ^ PAT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy    = 1'b0;
        m_doomed  = 1'b0;
        m_addr    = RESET_PC;
        m_next_pc = RESET_PC;
`ifdef FETCH_STATS_EN
        m_pushes  = 0;
        m_flushes = 0;
`endif
    endtask

    task automatic model_step();
        int          pre;
        logic [31:0] tgt;
        logic        do_pop;
        entry_t      e;
        pre    = m_q.size();
        tgt    = redirect_pc & 32'hFFFF_FFFC;
        do_pop = (pre > 0) && inst_ready && !redirect_valid;
        if (redirect_valid) begin
`ifdef FETCH_STATS_EN
            if (pre > 0 || (m_busy && !m_doomed)) m_flushes++;
`endif
            m_q.delete();
            m_next_pc = tgt;
            if (m_busy && !mem_ack) begin
                m_doomed = 1'b1;
            end else begin
                m_busy   = 1'b1;
                m_doomed = 1'b0;
                m_addr   = tgt;
            end
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (m_busy && mem_ack) begin
                if (m_doomed) begin
                    m_doomed = 1'b0;
                    m_addr   = m_next_pc;
                end else begin
                    e.pc   = m_addr;
                    e.data = m_addr ^ PAT;
                    m_q.push_back(e);
`ifdef FETCH_STATS_EN
                    m_pushes++;
`endif
                    m_next_pc = m_addr + 32'd4;
                    m_addr    = m_next_pc;
                    m_busy    = (m_q.size() < DEPTH);
                end
            end else if (!m_busy && pre < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_next_pc;
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_req", mem_req, m_busy);
        if (m_busy) chk("mem_addr", mem_addr, m_addr);
        chk("inst_valid", inst_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("inst_pc", inst_pc, m_q[0].pc);
            chk("inst_data", inst_data, m_q[0].data);
        end
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, 32'(m_pushes));
        chk("stat_flushed", stat_flushed, 32'(m_flushes));
`endif
    endtask

    task automatic at_neg();
        @(negedge clk);
        compare_all();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        model_reset();
        mem_ack        = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        mem_ack        = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        @(posedge clk);
        #2;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, RESET_PC);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_data", inst_data, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Zero-wait memory, core always ready: one instruction per cycle.
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        at_neg();
        at_pos();
        for (int k = 0; k < 8; k++) begin
            at_neg();
            chk("t1_addr", mem_addr, 32'(4 * k));
            chk("t1_valid", inst_valid, k > 0);
            if (k > 0) begin
                chk("t1_pc", inst_pc, 32'(4 * (k - 1)));
                chk("t1_data", inst_data, 32'(4 * (k - 1)) ^ PAT);
            end
            at_pos();
        end

        // Stalled core: FIFO fills to DEPTH, requests stop, then resume at 0x10.
        do_reset();
        mem_ack = 1'b1;
        repeat (8) begin
            at_neg();
            at_pos();
        end
        at_neg();
        chk("t2_req_low", mem_req, 1'b0);
        chk("t2_head_pc", inst_pc, 32'h0);
        chk("t2_valid", inst_valid, 1'b1);
        inst_ready = 1'b1;
        at_pos();
        at_neg();
        chk("t2_still_idle", mem_req, 1'b0);
        at_pos();
        at_neg();
        chk("t2_resume_req", mem_req, 1'b1);
        chk("t2_resume_addr", mem_addr, 32'h10);
        chk("t2_head_after", inst_pc, 32'h8);
        at_pos();

        // Slow memory with a redirect while the request is outstanding.
        do_reset();
        inst_ready = 1'b1;
        at_neg();
        at_pos();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        at_neg();
        at_pos();
        redirect_valid = 1'b0;
        at_neg();
        chk("t3_hold1", mem_addr, 32'h0);
        chk("t3_req1", mem_req, 1'b1);
        at_pos();
        at_neg();
        chk("t3_hold2", mem_addr, 32'h0);
        mem_ack = 1'b1;
        at_pos();
        at_neg();
        chk("t3_new_addr", mem_addr, 32'h100);
        chk("t3_dropped", inst_valid, 1'b0);
        at_pos();
        at_neg();
        chk("t3_first_pc", inst_pc, 32'h100);
        chk("t3_first_data", inst_data, 32'h0000A4A5);
        at_pos();

        // Redirect coinciding with ack and pop while two entries are queued.
        do_reset();
        mem_ack = 1'b1;
        at_neg();
        at_pos();
        at_neg();
        at_pos();
        at_neg();
        at_pos();
        at_neg();
        chk("t4_pre_pc", inst_pc, 32'h0);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        at_pos();
        redirect_valid = 1'b0;
        at_neg();
        chk("t4_flushed", inst_valid, 1'b0);
        chk("t4_addr", mem_addr, 32'h40);
        chk("t4_req", mem_req, 1'b1);
        at_pos();
        at_neg();
        chk("t4_first_pc", inst_pc, 32'h40);
        chk("t4_first_valid", inst_valid, 1'b1);

        // Asynchronous reset pulse between clock edges while a request is live.
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t5_req", mem_req, 1'b0);
        chk("t5_addr", mem_addr, RESET_PC);
        chk("t5_valid", inst_valid, 1'b0);
        chk("t5_pc", inst_pc, 32'h0);
        chk("t5_data", inst_data, 32'h0);
        #1;
        reset = 1'b0;
        at_pos();
        at_neg();
        chk("t5_restart_addr", mem_addr, RESET_PC);
        chk("t5_restart_req", mem_req, 1'b1);
        at_pos();
        at_neg();
        chk("t5_next_addr", mem_addr, RESET_PC + 32'd4);
        chk("t5_first_pc", inst_pc, RESET_PC);
        at_pos();

`ifdef FETCH_STATS_EN
        // Fill the stalled FIFO, then flush it once.
        do_reset();
        mem_ack = 1'b1;
        repeat (8) begin
            at_neg();
            at_pos();
        end
        at_neg();
        chk("t6_fetched_pre", stat_fetched, 32'd4);
        chk("t6_flushed_pre", stat_flushed, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        at_pos();
        redirect_valid = 1'b0;
        at_neg();
        chk("t6_fetched", stat_fetched, 32'd4);
        chk("t6_flushed", stat_flushed, 32'd1);
        chk("t6_addr", mem_addr, 32'h200);
        at_pos();
`endif

        at_neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
